// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use and branch stall FSM driving PC / IF/ID / ID/EX hold,
// flush and bubble controls. Define HAZARD_STATS_EN to enable the saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned BRANCH_STALL = 2,
    parameter int unsigned STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              flush,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              busy,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam int unsigned MAX_WIN = (LOAD_LAT > BRANCH_STALL) ? LOAD_LAT : BRANCH_STALL;
    localparam int unsigned CNT_W   = $clog2(MAX_WIN + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StBranch} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_use;

    // Stores forward rt mem-to-mem, so only rs can make a store wait on a load.
    assign load_use = idex_mem_read && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || ((idex_rt == ifid_rt) && !id_mem_write));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        busy        = 1'b0;

        case (state_q)
            StLoad: begin
                busy        = 1'b1;
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StBranch: begin
                busy        = 1'b1;
                idex_bubble = 1'b1;
                if (cnt_q > CNT_W'(1)) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                end else begin
                    // Release: the instruction behind the branch is squashed.
                    ifid_flush = 1'b1;
                    state_d    = StIdle;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = StIdle;
                if (load_use) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = StLoad;
                        cnt_d   = CNT_W'(LOAD_LAT - 1);
                    end
                end else if (id_branch) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    state_d    = StBranch;
                    cnt_d      = CNT_W'(BRANCH_STALL);
                end
            end
        endcase

        if (rst || flush) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            busy        = 1'b0;
            state_d     = StIdle;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else if (pc_stall && (stat_q != '1)) begin
            stat_q <= stat_q + STAT_W'(1);
        end
    end

    assign stall_cycles = stat_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table through a scoreboard queue plus hand-written
// multi-cycle sequences (long load window, async reset mid-window, stall counter saturation).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       idex_mem_read;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       id_mem_write, id_branch, flush;

    logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, busy;
    logic [1:0] stall_cycles;
    logic       pc_stall3, ifid_stall3, ifid_flush3, idex_bubble3, busy3;
    logic [15:0] stall_cycles3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BRANCH_STALL(2), .STAT_W(2)) dut (
        .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .flush(flush), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .busy(busy),
        .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BRANCH_STALL(3), .STAT_W(16)) dut3 (
        .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .flush(flush), .pc_stall(pc_stall3), .ifid_stall(ifid_stall3),
        .ifid_flush(ifid_flush3), .idex_bubble(idex_bubble3), .busy(busy3),
        .stall_cycles(stall_cycles3)
    );

    // Expected output bundle order: {pc_stall, ifid_stall, ifid_flush, idex_bubble, busy}
    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] xrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mw;
        logic       br;
        logic       fl;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic       sel;
        logic [4:0] exp;
    } sb_t;

    sb_t sb_q[$];

    function automatic logic [4:0] outs(input logic sel);
        if (sel) return {pc_stall3, ifid_stall3, ifid_flush3, idex_bubble3, busy3};
        return {pc_stall, ifid_stall, ifid_flush, idex_bubble, busy};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic mw, input logic br, input logic fl);
        idex_mem_read = mr;
        idex_rt       = xrt;
        ifid_rs       = rs;
        ifid_rt       = rt;
        id_mem_write  = mw;
        id_branch     = br;
        flush         = fl;
    endtask

    // Called at posedge+1: drive, push expectation, compare at negedge, return at next posedge+1.
    task automatic step(input vec_t v, input logic sel);
        sb_t e;
        sb_t got_e;
        drive(v.mr, v.xrt, v.rs, v.rt, v.mw, v.br, v.fl);
        e.name = v.name;
        e.sel  = sel;
        e.exp  = v.exp;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            got_e = sb_q.pop_front();
            check(got_e.name, {11'd0, outs(got_e.sel)}, {11'd0, got_e.exp});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    vec_t tbl[$];
    vec_t v;
    logic [1:0] stat_exp [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name            mr  xrt rs  rt  mw br fl  exp
        tbl.push_back('{"idle",         0, 0,  0,  0,  0, 0, 0, 5'b00000});
        tbl.push_back('{"lu_rs",        1, 3,  3,  0,  0, 0, 0, 5'b11010});
        tbl.push_back('{"lu_drop",      0, 3,  3,  0,  0, 0, 0, 5'b00000});
        tbl.push_back('{"x0_guard",     1, 0,  0,  0,  0, 0, 0, 5'b00000});
        tbl.push_back('{"store_rt",     1, 4,  1,  4,  1, 0, 0, 5'b00000});
        tbl.push_back('{"load_rt",      1, 4,  1,  4,  0, 0, 0, 5'b11010});
        tbl.push_back('{"no_match",     1, 5,  1,  2,  0, 0, 0, 5'b00000});
        tbl.push_back('{"br_c0",        0, 0,  1,  2,  0, 1, 0, 5'b11000});
        tbl.push_back('{"br_c1",        0, 0,  1,  2,  0, 1, 0, 5'b11011});
        tbl.push_back('{"br_release",   0, 0,  1,  2,  0, 1, 0, 5'b00111});
        tbl.push_back('{"br_idle",      0, 0,  1,  2,  0, 0, 0, 5'b00000});
        tbl.push_back('{"lu_over_br",   1, 2,  2,  0,  0, 1, 0, 5'b11010});
        tbl.push_back('{"br_after_lu",  0, 2,  2,  0,  0, 1, 0, 5'b11000});
        tbl.push_back('{"flush_br",     0, 2,  2,  0,  0, 1, 1, 5'b00000});
        tbl.push_back('{"after_flush",  0, 2,  2,  0,  0, 0, 0, 5'b00000});
        tbl.push_back('{"flush_lu",     1, 3,  3,  0,  0, 0, 1, 5'b00000});
        tbl.push_back('{"flush_done",   0, 0,  0,  0,  0, 0, 0, 5'b00000});

        // Reset state with a live hazard on the inputs: everything forced low.
        rst = 1'b1;
        drive(1, 3, 3, 0, 0, 1, 0);
        #1;
        check("rst_forces_outs", {11'd0, outs(1'b0)}, 16'd0);
        check("rst_forces_outs3", {11'd0, outs(1'b1)}, 16'd0);
        check("rst_stat", {14'd0, stall_cycles}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], 1'b0);

        // Three-bubble load window on the LOAD_LAT=3 instance; inputs drop after detection.
        do_reset();
        v = '{"l3_c0", 1, 3, 3, 0, 0, 0, 0, 5'b11010};
        step(v, 1'b1);
        v = '{"l3_c1", 0, 0, 0, 0, 0, 0, 0, 5'b11011};
        step(v, 1'b1);
        v = '{"l3_c2", 0, 0, 0, 0, 0, 1, 0, 5'b11011};
        step(v, 1'b1);
        v = '{"l3_c3", 0, 0, 0, 0, 0, 0, 0, 5'b00000};
        step(v, 1'b1);

        // Async reset mid-LOAD: outputs drop before any clock edge, state returns to IDLE.
        do_reset();
        drive(1, 6, 6, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("l3_in_load_busy", {15'd0, busy3}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_load", {11'd0, outs(1'b1)}, 16'd0);
        check("rst_mid_load_main", {11'd0, outs(1'b0)}, 16'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("after_rst_idle", {11'd0, outs(1'b1)}, 16'd0);
        @(posedge clk);
        #1;

        // Stall statistic: five stalled edges on a 2-bit counter.
`ifdef HAZARD_STATS_EN
        stat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        stat_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        do_reset();
        check("stat_after_rst", {14'd0, stall_cycles}, 16'd0);
        drive(1, 7, 7, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stat_%0d", i), {14'd0, stall_cycles}, {14'd0, stat_exp[i]});
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("stat_hold", {14'd0, stall_cycles}, {14'd0, stat_exp[4]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the single-cycle load-use/branch hazard detector.
- Sits in the ID stage of the 5-stage pipeline and drives the PC, IF/ID and ID/EX control-mux hold/flush signals.
- Adds a stall FSM with configurable load-use latency and branch-penalty windows, an x0 guard, an external flush, and an optional stall counter.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 1, load-use bubbles inserted per hazard (>=1; >1 for multi-cycle data memory)
BRANCH_STALL, 2, cycles the PC is held after a branch is decoded (>=1)
STAT_W, 16, stall counter width (used only with HAZARD_STATS_EN)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
idex_mem_read  in  1  instruction in EX is a load
idex_rt  in  REG_AW  load destination register
ifid_rs  in  REG_AW  ID-stage source register rs
ifid_rt  in  REG_AW  ID-stage source register rt
id_mem_write  in  1  ID instruction is a store (rt is store data, forwarded mem-to-mem)
id_branch  in  1  ID instruction is a branch
flush  in  1  synchronous abort from exception/redirect
pc_stall  out  1  1 = PC holds its value
ifid_stall  out  1  1 = IF/ID holds its value
ifid_flush  out  1  1 = IF/ID loads a NOP
idex_bubble  out  1  1 = control mux zeroes ID/EX control
busy  out  1  FSM not in IDLE
stall_cycles  out  STAT_W  stall statistic

Behaviour:
- States: IDLE, LOAD, BRANCH. Down-counter cnt, width $clog2(max(LOAD_LAT, BRANCH_STALL)+1).
- load_use = idex_mem_read && idex_rt!=0 && (idex_rt==ifid_rs || (idex_rt==ifid_rt && !id_mem_write)). A destination of register 0 never stalls.
- Outputs are Mealy. They are combinational from state, cnt and inputs.
- Default output values: all 0.

IDLE:
- load_use: pc_stall=ifid_stall=idex_bubble=1.
  - If LOAD_LAT>1, go to LOAD with cnt=LOAD_LAT-1.
  - Otherwise stay in IDLE.
- Else if id_branch: pc_stall=ifid_stall=1, idex_bubble=0 (the branch advances to EX). Go to BRANCH with cnt=BRANCH_STALL.
- Load-use has priority over branch, because the branch may read the load result. The branch is re-detected once the load stall ends.

LOAD:
- pc_stall=ifid_stall=idex_bubble=1. Inputs are ignored.
- Each cycle cnt decrements. When cnt==1, go to IDLE.
- Total bubbles per load-use hazard = LOAD_LAT.

BRANCH:
- While cnt>1: pc_stall=ifid_stall=idex_bubble=1, and cnt decrements. id_branch is ignored because IF/ID still holds the branch.
- When cnt==1 (release cycle): pc_stall=0, ifid_stall=0, ifid_flush=1, idex_bubble=1. Go to IDLE.
- Total PC-held cycles = BRANCH_STALL. The release cycle follows them.

Other rules:
- busy = (state != IDLE).
- flush, in any state: all outputs except stall_cycles are 0 that cycle. Next state is IDLE and cnt=0. flush overrides a simultaneous load_use/id_branch.
- rst (asynchronous, any time, including mid-window): state=IDLE, cnt=0, stall_cycles=0. While rst is high, every output is forced to 0 regardless of inputs.
- No X propagation: unknown states decode as IDLE.

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_cycles increments on every clock edge where pc_stall==1 and rst==0. It saturates at all-ones (no wrap) and clears only on reset.
- Undefined: the stall_cycles port still exists, tied to 0, with no counter logic, so instantiations are identical.

Test Plan:
1. LOAD_LAT=1: idex_mem_read=1, idex_rt=3, ifid_rs=3 -> one cycle with pc_stall=ifid_stall=idex_bubble=1, busy=0. Then all 0 once idex_mem_read drops.
2. idex_rt=0 with matching rs, and separately idex_rt=4=ifid_rt with id_mem_write=1 -> no stall. The same case with id_mem_write=0 -> stall.
3. LOAD_LAT=3 with a hazard at cycle 0 -> idex_bubble=1 on cycles 0,1,2; busy=1 on cycles 1,2; IDLE at cycle 3.
4. BRANCH_STALL=2, id_branch=1 held:
   - cycle 0: pc_stall=1, idex_bubble=0
   - cycle 1: pc_stall=1, idex_bubble=1
   - cycle 2: pc_stall=0, ifid_flush=1, idex_bubble=1
   - cycle 3: IDLE
5. load_use and id_branch together -> LOAD first. Assert flush during BRANCH cycle 1 -> all outputs 0 that cycle, IDLE next. Assert rst mid-LOAD -> outputs 0 immediately, before the clock edge.
6. With HAZARD_STATS_EN and STAT_W=2: 5 stall cycles -> stall_cycles reads 1,2,3,3,3. Without the macro -> stall_cycles stays 0.
